// File: rtl/ripple_carry_adder_seq_param.sv
// Multi-cycle add/subtract unit: CHUNK bits per cycle through a ripple slice, LSB chunk first.
// Latency WIDTH/CHUNK cycles after accepted start. Start is ignored while busy. Define RCA_SEQ_OVF_EN to add the Ovf output.
module ripple_carry_adder_seq_param #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef RCA_SEQ_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
   localparam int N          = WIDTH / CHUNK_SAFE;
   localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   generate
      if (CHUNK < 1) begin : g_bad_chunk
         $error("ripple_carry_adder_seq_param: CHUNK must be at least 1");
      end else if (WIDTH % CHUNK != 0) begin : g_bad_width
         $error("ripple_carry_adder_seq_param: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] bx_q;
   logic [WIDTH-1:0] sum_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk_d;
   logic             c_chunk_d;
`ifdef RCA_SEQ_OVF_EN
   logic             c_msb_in_d;
   logic             ovf_q;
`endif

   // Bit-serial carry chain across the current chunk; no lookahead.
   always_comb begin : p_ripple
      logic c;
      a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk   = bx_q[idx_q*CHUNK +: CHUNK];
      s_chunk_d = '0;
      c         = carry_q;
`ifdef RCA_SEQ_OVF_EN
      c_msb_in_d = 1'b0;
`endif
      for (int i = 0; i < CHUNK; i++) begin
`ifdef RCA_SEQ_OVF_EN
         c_msb_in_d = c;
`endif
         s_chunk_d[i] = a_chunk[i] ^ b_chunk[i] ^ c;
         c            = (a_chunk[i] & b_chunk[i]) | (c & (a_chunk[i] ^ b_chunk[i]));
      end
      c_chunk_d = c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         bx_q    <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  // Subtract folds into add: invert B here, force carry-in to 1.
                  a_q     <= A;
                  bx_q    <= B ^ {WIDTH{Sub}};
                  carry_q <= Sub | Cin;
                  idx_q   <= '0;
                  cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
                  ovf_q   <= 1'b0;
`endif
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q[idx_q*CHUNK +: CHUNK] <= s_chunk_d;
               carry_q <= c_chunk_d;
               if (idx_q == LAST_IDX) begin
                  cout_q  <= c_chunk_d;
`ifdef RCA_SEQ_OVF_EN
                  ovf_q   <= c_msb_in_d ^ c_chunk_d;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;
`ifdef RCA_SEQ_OVF_EN
   assign Ovf  = ovf_q;
`endif

endmodule
